// File: rtl/wb_stage_pkg.sv
// Shared widths and device-load FSM encodings for the write-back stage.
package wb_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int HILO_W = 64;
    localparam int DRE_W  = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dev_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load lane selection with sign/zero extension.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0]  data_i,
    input  logic [DRE_W-1:0] dre_i,
    input  logic             unsign_i,
    output logic [XLEN-1:0]  data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = '0;
        h      = '0;
        data_o = '0;
        case (dre_i)
            4'b0001: b = data_i[7:0];
            4'b0010: b = data_i[15:8];
            4'b0100: b = data_i[23:16];
            4'b1000: b = data_i[31:24];
            4'b0011: h = data_i[15:0];
            4'b1100: h = data_i[31:16];
            default: ;
        endcase
        case (dre_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                data_o = {{24{b[7] & ~unsign_i}}, b};
            4'b0011, 4'b1100:
                data_o = {{16{h[15] & ~unsign_i}}, h};
            4'b1111:
                data_o = data_i;
            default:
                data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load alignment, device-load wait FSM, GPR and HI/LO write.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              wb_unsign,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic              wb_wreg,
    input  logic              wb_whilo,
    input  logic              wb_mreg,
    input  logic [XLEN-1:0]   wb_dreg,
    input  logic [HILO_W-1:0] wb_dhilo,
    input  logic [DRE_W-1:0]  wb_dre,
    input  logic              wb_device,
    input  logic [XLEN-1:0]   dm_rdata,
    input  logic              dev_rvalid,
    input  logic [XLEN-1:0]   dev_rdata,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [XLEN-1:0]   rf_wd,
    output logic [XLEN-1:0]   hi_o,
    output logic [XLEN-1:0]   lo_o,
    output logic              dev_rreq,
    output logic              wb_stall,
    output logic              dev_timeout
);

    dev_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  buf_q, buf_d;
    logic [XLEN-1:0]  hi_q, lo_q;
    logic [XLEN-1:0]  dm_al, buf_al;
    logic             rreq, stall, tmo;

    load_align u_dm_align (
        .data_i   (dm_rdata),
        .dre_i    (wb_dre),
        .unsign_i (wb_unsign),
        .data_o   (dm_al)
    );

    load_align u_buf_align (
        .data_i   (buf_q),
        .dre_i    (wb_dre),
        .unsign_i (wb_unsign),
        .data_o   (buf_al)
    );

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        rreq    = 1'b0;
        stall   = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_mreg && wb_device && !flush) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    stall   = 1'b1;
                end
            end
            WAIT: begin
                rreq  = 1'b1;
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                // data beats the timeout when both land together
                if (flush) begin
                    state_d = IDLE;
                end else if (dev_rvalid) begin
                    buf_d   = dev_rdata;
                    state_d = DONE;
                end else if (cnt_q == '1) begin
                    buf_d   = '0;
                    tmo     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // keep handshake outputs quiet while reset is held
    assign wb_stall    = stall & ~cpu_rst;
    assign dev_rreq    = rreq & ~cpu_rst;
    assign dev_timeout = tmo & ~cpu_rst;

    assign rf_we = wb_wreg & (|wb_wa) & ~wb_stall & ~flush & ~cpu_rst;
    assign rf_wa = wb_wa;

    always_comb begin
        rf_wd = wb_dreg;
        if (wb_mreg) begin
            rf_wd = wb_device ? buf_al : dm_al;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo && !wb_stall && !flush) begin
            hi_q <= wb_dhilo[63:32];
            lo_q <= wb_dhilo[31:0];
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a behavioural model.
module tb_wb_stage;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        wb_unsign = 1'b0;
    logic [4:0]  wb_wa = 5'd5;
    logic        wb_wreg = 1'b1;
    logic        wb_whilo = 1'b1;
    logic        wb_mreg = 1'b1;
    logic [31:0] wb_dreg = 32'h0;
    logic [63:0] wb_dhilo = 64'h1234_5678_9ABC_DEF0;
    logic [3:0]  wb_dre = 4'hF;
    logic        wb_device = 1'b1;
    logic [31:0] dm_rdata = 32'h0;
    logic        dev_rvalid = 1'b0;
    logic [31:0] dev_rdata = 32'h0;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] hi_o, lo_o;
    logic        dev_rreq, wb_stall, dev_timeout;

    wb_stage dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .wb_unsign   (wb_unsign),
        .wb_wa       (wb_wa),
        .wb_wreg     (wb_wreg),
        .wb_whilo    (wb_whilo),
        .wb_mreg     (wb_mreg),
        .wb_dreg     (wb_dreg),
        .wb_dhilo    (wb_dhilo),
        .wb_dre      (wb_dre),
        .wb_device   (wb_device),
        .dm_rdata    (dm_rdata),
        .dev_rvalid  (dev_rvalid),
        .dev_rdata   (dev_rdata),
        .flush       (flush),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .dev_rreq    (dev_rreq),
        .wb_stall    (wb_stall),
        .dev_timeout (dev_timeout)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference: pick contiguous aligned lanes, shift down, extend by size.
    function automatic logic [31:0] m_align(input logic [31:0] w,
                                            input logic [3:0] dre,
                                            input logic uns);
        int n;
        int lo;
        logic [3:0] pat;
        logic [31:0] v;
        n = $countones(dre);
        lo = 0;
        for (int i = 3; i >= 0; i--) if (dre[i]) lo = i;
        pat = 4'b0011;
        pat = pat << lo;
        v = w >> (8 * lo);
        if (n == 1) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2 && (lo == 0 || lo == 2) && dre == pat) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else if (n != 4) begin
            v = 32'h0;
        end
        return v;
    endfunction

    task automatic cyc(input string tag, input logic e_stall,
                       input logic [31:0] e_wd, input logic e_rreq,
                       input logic e_to);
        logic e_we;
        #2;
        e_we = wb_wreg && (wb_wa != 5'd0) && !e_stall && !flush;
        chk({tag, ".stall"}, 64'(wb_stall), 64'(e_stall));
        chk({tag, ".we"}, 64'(rf_we), 64'(e_we));
        chk({tag, ".rreq"}, 64'(dev_rreq), 64'(e_rreq));
        chk({tag, ".tmo"}, 64'(dev_timeout), 64'(e_to));
        chk({tag, ".wa"}, 64'(rf_wa), 64'(wb_wa));
        if (e_we) chk({tag, ".wd"}, 64'(rf_wd), 64'(e_wd));
        @(posedge cpu_clk_50M);
        if (wb_whilo && !e_stall && !flush) {m_hi, m_lo} = wb_dhilo;
        #1;
        chk({tag, ".hi"}, 64'(hi_o), 64'(m_hi));
        chk({tag, ".lo"}, 64'(lo_o), 64'(m_lo));
        @(negedge cpu_clk_50M);
    endtask

    task automatic set_alu();
        wb_mreg = 1'b0;
        wb_device = 1'b0;
        wb_wreg = 1'b0;
        wb_whilo = 1'b0;
        flush = 1'b0;
        dev_rvalid = 1'b0;
    endtask

    function automatic logic [3:0] rand_dre();
        logic [3:0] t [8];
        t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0011, 4'b1100, 4'b1111, 4'b0000};
        if ($urandom_range(0, 7) == 0) return 4'($urandom);
        return t[$urandom_range(0, 7)];
    endfunction

    task automatic rand_dev_inputs();
        wb_wa = 5'($urandom_range(1, 31));
        wb_wreg = 1'b1;
        wb_mreg = 1'b1;
        wb_device = 1'b1;
        wb_dre = rand_dre();
        wb_unsign = 1'($urandom);
        wb_whilo = 1'($urandom);
        wb_dhilo = {$urandom, $urandom};
        wb_dreg = $urandom;
        dm_rdata = $urandom;
        flush = 1'b0;
    endtask

    // lat=0 means the device never answers; flush_at=0 means no flush
    task automatic dev_load(input int lat, input logic [31:0] d,
                            input int flush_at);
        logic fin;
        fin = 1'b0;
        cyc("dl.idle", 1'b1, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 256 && !fin; k++) begin
            if (k == flush_at) begin
                flush = 1'b1;
                dev_rvalid = 1'b0;
                cyc("dl.flush", 1'b1, 32'h0, 1'b1, 1'b0);
                set_alu();
                return;
            end
            dev_rvalid = (k == lat);
            dev_rdata = dev_rvalid ? d : $urandom;
            cyc("dl.wait", 1'b1, 32'h0, 1'b1, (lat == 0 && k == 256));
            if (k == lat) fin = 1'b1;
        end
        dev_rvalid = 1'b0;
        cyc("dl.done", 1'b0, m_align((lat != 0) ? d : 32'h0, wb_dre,
            wb_unsign), 1'b0, 1'b0);
        set_alu();
    endtask

    task automatic rand_sram_cycle();
        wb_wa = 5'($urandom);
        wb_wreg = 1'($urandom);
        wb_mreg = 1'($urandom);
        wb_device = 1'b0;
        wb_dre = rand_dre();
        wb_unsign = 1'($urandom);
        wb_whilo = 1'($urandom);
        wb_dhilo = {$urandom, $urandom};
        wb_dreg = $urandom;
        dm_rdata = $urandom;
        flush = ($urandom_range(0, 7) == 0);
        cyc("rnd", 1'b0, wb_mreg ? m_align(dm_rdata, wb_dre, wb_unsign)
            : wb_dreg, 1'b0, 1'b0);
    endtask

    initial begin
        #3;
        chk("rst.rreq", 64'(dev_rreq), 64'h0);
        chk("rst.stall", 64'(wb_stall), 64'h0);
        chk("rst.we", 64'(rf_we), 64'h0);
        chk("rst.tmo", 64'(dev_timeout), 64'h0);
        chk("rst.hi", 64'(hi_o), 64'h0);
        chk("rst.lo", 64'(lo_o), 64'h0);
        @(posedge cpu_clk_50M);
        #1;
        chk("rst.hi2", 64'(hi_o), 64'h0);
        set_alu();
        @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;

        // SRAM byte / half loads
        wb_mreg = 1'b1; wb_wreg = 1'b1; wb_wa = 5'd3;
        dm_rdata = 32'h80FF_7F01; wb_dre = 4'b0010; wb_unsign = 1'b0;
        #2;
        chk("sram.b1", 64'(rf_wd), 64'h0000_007F);
        cyc("sram.b1", 1'b0, 32'h0000_007F, 1'b0, 1'b0);
        wb_dre = 4'b1100;
        cyc("sram.hs", 1'b0, 32'hFFFF_80FF, 1'b0, 1'b0);
        wb_unsign = 1'b1;
        cyc("sram.hu", 1'b0, 32'h0000_80FF, 1'b0, 1'b0);

        // HI/LO write, then a flushed write that must not land
        set_alu();
        wb_whilo = 1'b1; wb_dhilo = 64'hAAAA_0000_0000_5555;
        cyc("hilo", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("hilo.hi", 64'(hi_o), 64'hAAAA_0000);
        chk("hilo.lo", 64'(lo_o), 64'h0000_5555);
        wb_dhilo = 64'h1111_2222_3333_4444; flush = 1'b1;
        cyc("hilo.fl", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("hilo.flhi", 64'(hi_o), 64'hAAAA_0000);
        set_alu();

        // device word load answered in the third WAIT cycle
        rand_dev_inputs();
        wb_dre = 4'b1111; wb_whilo = 1'b0;
        dev_load(3, 32'h1234_5678, 0);
        cyc("dl.idle_after", 1'b0, 32'h0, 1'b0, 1'b0);

        // timeout, and data landing exactly at counter 255
        rand_dev_inputs();
        dev_load(0, 32'h0, 0);
        rand_dev_inputs();
        dev_load(256, $urandom, 0);

        // flush mid-WAIT, then a late dev_rvalid that must be ignored
        rand_dev_inputs();
        dev_load(5, 32'h0, 2);
        dev_rvalid = 1'b1; dev_rdata = 32'hDEAD_BEEF;
        wb_wreg = 1'b1; wb_wa = 5'd9; wb_dreg = 32'h0BAD_F00D;
        cyc("late", 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
        rand_dev_inputs();
        wb_dre = 4'b1111;
        dev_load(1, 32'hCAFE_0001, 0);

        // reset in the middle of WAIT
        rand_dev_inputs();
        cyc("rw.idle", 1'b1, 32'h0, 1'b0, 1'b0);
        dev_rvalid = 1'b0;
        cyc("rw.wait", 1'b1, 32'h0, 1'b1, 1'b0);
        cpu_rst = 1'b1;
        #1;
        chk("rw.rreq", 64'(dev_rreq), 64'h0);
        chk("rw.stall", 64'(wb_stall), 64'h0);
        chk("rw.we", 64'(rf_we), 64'h0);
        chk("rw.hi", 64'(hi_o), 64'h0);
        chk("rw.lo", 64'(lo_o), 64'h0);
        m_hi = 32'h0; m_lo = 32'h0;
        set_alu();
        @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;
        cyc("rw.post", 1'b0, 32'h0, 1'b0, 1'b0);

        // random mix
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_dev_inputs();
                dev_load($urandom_range(1, 6), $urandom,
                         ($urandom_range(0, 4) == 0) ?
                         $urandom_range(1, 3) : 0);
            end else begin
                rand_sram_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset: cpu_clk_50M is the one clock and cpu_rst is the reset.
REQ-002 Ports SHALL be, clock and reset first:
- cpu_clk_50M  in  1  pipeline clock
- cpu_rst  in  1  async reset, active-high
- wb_unsign  in  1  zero-extend load when 1
- wb_wa  in  5  destination GPR
- wb_wreg  in  1  GPR write request
- wb_whilo  in  1  HI/LO write request
- wb_mreg  in  1  result is load data (else wb_dreg)
- wb_dreg  in  32  ALU result
- wb_dhilo  in  64  {HI,LO} value
- wb_dre  in  4  byte-lane read enables
- wb_device  in  1  load targets uncached device
- dm_rdata  in  32  data SRAM read word, valid this cycle
- dev_rvalid  in  1  device read data valid
- dev_rdata  in  32  device read word
- flush  in  1  exception flush
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data
- hi_o, lo_o  out  32 each  architectural HI, LO
- dev_rreq  out  1  device read request
- wb_stall  out  1  hold memwb_reg and all upstream stages
- dev_timeout  out  1  one-cycle pulse on device timeout

Function
REQ-003 Lane selection SHALL be: dre 0001/0010/0100/1000 selects byte 0/1/2/3; 0011/1100 selects low/high half; 1111 selects the whole word; any other dre yields 0.
REQ-004 Byte and half results SHALL be sign-extended when wb_unsign=0 and zero-extended when wb_unsign=1.
REQ-005 When wb_mreg=0, rf_wd SHALL equal wb_dreg.
REQ-006 When wb_mreg=1 and wb_device=0, rf_wd SHALL be the aligned dm_rdata in the same cycle, with no stall.
REQ-007 The device-load FSM SHALL have states IDLE, WAIT and DONE.
REQ-008 In IDLE with wb_mreg&wb_device&!flush, the FSM SHALL go to WAIT; wb_stall=1 combinationally in that cycle and rf_we=0.
REQ-009 In WAIT, dev_rreq SHALL be 1, wb_stall SHALL be 1 and the 8-bit timeout counter SHALL increment each cycle.
REQ-010 In WAIT, dev_rvalid=1 SHALL capture dev_rdata into a 32-bit buffer and move the FSM to DONE.
REQ-011 In WAIT, a counter value of 255 without dev_rvalid SHALL load the buffer with 0, pulse dev_timeout and move the FSM to DONE.
REQ-012 In DONE, wb_stall SHALL be 0, rf_wd SHALL be the aligned buffer, and the FSM SHALL return to IDLE next cycle.
REQ-013 Device-load latency SHALL be (cycles until dev_rvalid) + 2.
REQ-014 rf_we SHALL equal wb_wreg & (wb_wa!=0) & !wb_stall & !flush.
REQ-015 rf_wa SHALL equal wb_wa.
REQ-016 The HI/LO register SHALL load wb_dhilo on the clock edge where wb_whilo & !wb_stall & !flush.
REQ-017 hi_o/lo_o SHALL present the registered HI/LO values, with no bypass.
REQ-018 flush in WAIT SHALL return the FSM to IDLE next cycle, drop dev_rreq and perform no GPR write; a late dev_rvalid in IDLE SHALL be ignored.
REQ-019 dev_rvalid arriving in the same cycle as a counter value of 255 SHALL take the data path, with no timeout pulse.
REQ-020 Upstream SHALL hold all wb_* inputs stable while wb_stall=1.

Reset
REQ-021 cpu_rst SHALL asynchronously force FSM=IDLE, counter=0, buffer=0, HI=LO=0.
REQ-022 The outputs SHALL take these values during cpu_rst: dev_rreq=0, dev_timeout=0, wb_stall=0, rf_we=0.
REQ-023 Reset asserted mid-WAIT SHALL abandon the device read with no GPR write.

Structure
REQ-024 Bus widths and the IDLE/WAIT/DONE encodings SHALL live in the shared defines package.
REQ-025 Lane selection and extension SHALL be one combinational sub-module, load_align, instantiated twice: once for dm_rdata and once for the buffer.

Verification
REQ-026 dm_rdata=0x80FF7F01, dre=0010, unsign=0, mreg=1, wreg=1, wa=3 -> rf_we=1, rf_wa=3, rf_wd=0x0000007F, same cycle.
REQ-027 Same data with dre=1100, unsign=0 -> rf_wd=0xFFFF80FF; with unsign=1 -> rf_wd=0x000080FF.
REQ-028 Device word load, dev_rvalid after 3 WAIT cycles with 0x12345678 -> wb_stall high 4 cycles, rf_we=1 with rf_wd=0x12345678 in DONE, FSM back in IDLE.
REQ-029 Device load with no dev_rvalid -> dev_timeout pulse after 256 WAIT cycles, rf_wd=0 in DONE.
REQ-030 wb_whilo=1, dhilo=0xAAAA_0000_0000_5555 -> hi_o=0xAAAA0000, lo_o=0x00005555 next cycle; flush=1 in that cycle -> values unchanged.
REQ-031 cpu_rst pulse during WAIT -> dev_rreq=0 and wb_stall=0 immediately, HI/LO=0, no rf_we.
